// File: rtl/fetch_pair_sequencer_pkg.sv
// Shared types and encodings for the dual-bank fetch sequencer.
//   fetch_state_e : sequencer state, encoded as presented on state_o
//   SEL0_*        : IR_0 steering select encodings (sel_mem_0_o)
//   SEL1_*        : IR_1 steering select encodings (sel_mem_1_o)
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALT   = 2'd3
    } fetch_state_e;

    localparam logic [1:0] SEL0_DATA0 = 2'd0;
    localparam logic [1:0] SEL0_IR1   = 2'd1;  // reserved, never driven by the sequencer
    localparam logic [1:0] SEL0_DATA1 = 2'd2;

    localparam logic SEL1_DATA0 = 1'b0;
    localparam logic SEL1_DATA1 = 1'b1;

endpackage

// File: rtl/fetch_pair_sequencer_if.sv
// Decode/ROM-facing bundle of the fetch sequencer.
//   master : decode side, drives start/stall/issue/branch, observes fetch outputs
//   slave  : sequencer side, the reverse
interface fetch_pair_sequencer_if #(
    parameter int ROW_W = 14,
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             stall_i;
    logic [1:0]       issue_cnt_i;
    logic             branch_valid_i;
    logic [ROW_W:0]   branch_target_i;
    logic [ROW_W-1:0] rom_addr_o;
    logic             pc_1_o;
    logic             sel_mem_1_o;
    logic [1:0]       sel_mem_0_o;
    logic [1:0]       ir_valid_o;
    logic [ROW_W:0]   pc_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] issued_cnt_o;

    modport master (
        output start_i, stall_i, issue_cnt_i, branch_valid_i, branch_target_i,
        input  rom_addr_o, pc_1_o, sel_mem_1_o, sel_mem_0_o, ir_valid_o, pc_o,
               state_o, issued_cnt_o
    );

    modport slave (
        input  start_i, stall_i, issue_cnt_i, branch_valid_i, branch_target_i,
        output rom_addr_o, pc_1_o, sel_mem_1_o, sel_mem_0_o, ir_valid_o, pc_o,
               state_o, issued_cnt_o
    );
endinterface

// File: rtl/fetch_pair_sequencer_steer.sv
// fetch_bank_steer: combinational PC -> ROM row / bank steering map.
//   pc_i        : halfword PC
//   rom_addr_o  : ROM row, PC>>1
//   pc_1_o      : PC[0]; bank 0 reads row+1 when the PC is odd
//   sel_mem_1_o : IR_1 source (data_1 for even PC, data_0 for odd PC)
//   sel_mem_0_o : IR_0 source (data_0 for even PC, data_1 for odd PC)
module fetch_bank_steer
    import fetch_pkg::*;
#(
    parameter int ROW_W = 14
) (
    input  logic [ROW_W:0]   pc_i,
    output logic [ROW_W-1:0] rom_addr_o,
    output logic             pc_1_o,
    output logic             sel_mem_1_o,
    output logic [1:0]       sel_mem_0_o
);
    // Odd PC: IR_0 comes from bank 1 of row R, IR_1 from bank 0 of row R+1,
    // so the pair always covers PC and PC+1 without a stale row.
    assign rom_addr_o  = pc_i[ROW_W:1];
    assign pc_1_o      = pc_i[0];
    assign sel_mem_1_o = pc_i[0] ? SEL1_DATA0 : SEL1_DATA1;
    assign sel_mem_0_o = pc_i[0] ? SEL0_DATA1 : SEL0_DATA0;
endmodule

// File: rtl/fetch_pair_sequencer.sv
// fetch_pair_sequencer: owns the halfword PC of the dual-bank program ROM.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of fetch_pair_sequencer_if (start/stall/issue/branch in;
//                ROM steering, IR valids, PC, state and issued count out)
// Advances the PC by the number of instructions decode accepted, redirects on
// branch through a one-cycle bubble, and halts past the end of the program.
module fetch_pair_sequencer
    import fetch_pkg::*;
#(
    parameter int ROW_W    = 14,
    parameter int PROG_LEN = 19,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_pair_sequencer_if.slave bus
);
    localparam int PC_W = ROW_W + 1;
    // One extra bit so PC+1 and the end-of-program compare never wrap.
    localparam logic [PC_W:0] PROG_LEN_X = (PC_W + 1)'(PROG_LEN);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;

    logic [1:0]      ir_valid;
    logic [1:0]      valid_cnt;
    logic [1:0]      issue_req;
    logic [1:0]      acc;
    logic [PC_W:0]   pc_x;

    assign pc_x = {1'b0, pc_q};

    always_comb begin
        ir_valid = 2'b00;
        if (state_q == ST_RUN) begin
            ir_valid[0] = (pc_x < PROG_LEN_X);
            ir_valid[1] = ((pc_x + 1'b1) < PROG_LEN_X);
        end
        valid_cnt = {1'b0, ir_valid[0]} + {1'b0, ir_valid[1]};
        issue_req = (bus.stall_i || bus.issue_cnt_i == 2'd3) ? 2'd0 : bus.issue_cnt_i;
        acc       = (issue_req > valid_cnt) ? valid_cnt : issue_req;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        issued_cnt_d = issued_cnt_q;
        if (state_q != ST_IDLE && bus.branch_valid_i) begin
            pc_d    = bus.branch_target_i;
            state_d = ST_BUBBLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (bus.start_i) state_d = ST_RUN;
                ST_BUBBLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (acc != 2'd0) begin
                        pc_d         = pc_q + PC_W'(acc);
                        issued_cnt_d = issued_cnt_q + CNT_W'(acc);
                    end
                    if ({1'b0, pc_d} >= PROG_LEN_X) state_d = ST_HALT;
                end
                ST_HALT:   state_d = ST_HALT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous -- rst_n matters only at the rising edge, and
    // sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= PC_W'(RESET_PC);
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    fetch_bank_steer #(.ROW_W(ROW_W)) u_steer (
        .pc_i        (pc_q),
        .rom_addr_o  (bus.rom_addr_o),
        .pc_1_o      (bus.pc_1_o),
        .sel_mem_1_o (bus.sel_mem_1_o),
        .sel_mem_0_o (bus.sel_mem_0_o)
    );

    assign bus.ir_valid_o   = ir_valid;
    assign bus.pc_o         = pc_q;
    assign bus.state_o      = state_q;
    assign bus.issued_cnt_o = issued_cnt_q;
endmodule

// File: tb/tb_fetch_pair_sequencer.sv
// Directed self-checking bench for fetch_pair_sequencer (ROW_W=14, PROG_LEN=19,
// RESET_PC=0, CNT_W=32). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the edge.
module tb_fetch_pair_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_pair_sequencer_if #(.ROW_W(14), .CNT_W(32)) bus ();

    fetch_pair_sequencer #(
        .ROW_W(14), .PROG_LEN(19), .RESET_PC(0), .CNT_W(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core architectural state.
    task automatic expect_core(input string tag, input int pc, input int st,
                               input int iv, input int cnt);
        check({tag, ".pc"},    64'(bus.pc_o),         64'(pc));
        check({tag, ".state"}, 64'(bus.state_o),      64'(st));
        check({tag, ".irv"},   64'(bus.ir_valid_o),   64'(iv));
        check({tag, ".cnt"},   64'(bus.issued_cnt_o), 64'(cnt));
    endtask

    // ROM steering outputs.
    task automatic expect_steer(input string tag, input int row, input int p1,
                                input int s1, input int s0);
        check({tag, ".row"}, 64'(bus.rom_addr_o),  64'(row));
        check({tag, ".pc1"}, 64'(bus.pc_1_o),      64'(p1));
        check({tag, ".s1"},  64'(bus.sel_mem_1_o), 64'(s1));
        check({tag, ".s0"},  64'(bus.sel_mem_0_o), 64'(s0));
    endtask

    task automatic drive(input logic st, input logic sl, input logic [1:0] ic,
                         input logic bv, input logic [14:0] bt);
        bus.start_i         = st;
        bus.stall_i         = sl;
        bus.issue_cnt_i     = ic;
        bus.branch_valid_i  = bv;
        bus.branch_target_i = bt;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 2'd0, 0, 15'd0);

        // Reset state.
        tick();
        expect_core("rst", 0, 0, 0, 0);
        expect_steer("rst", 0, 0, 1, 0);

        // Start, then issue two per cycle for three cycles.
        rst_n = 1'b1;
        drive(1, 0, 2'd0, 0, 15'd0);
        tick();
        expect_core("start", 0, 1, 3, 0);
        drive(0, 0, 2'd2, 0, 15'd0);
        tick();
        expect_core("run2a", 2, 1, 3, 2);
        check("run2a.row", 64'(bus.rom_addr_o), 64'd1);
        tick();
        expect_core("run2b", 4, 1, 3, 4);
        check("run2b.row", 64'(bus.rom_addr_o), 64'd2);
        tick();
        expect_core("run2c", 6, 1, 3, 6);
        expect_steer("run2c", 3, 0, 1, 0);

        // rst_n low only between edges has no effect.
        drive(0, 0, 2'd0, 0, 15'd0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        expect_core("glitch", 6, 1, 3, 6);

        // Reset at an edge while RUN at PC=6; start on that edge is ignored.
        rst_n = 1'b0;
        drive(1, 0, 2'd2, 0, 15'd0);
        tick();
        expect_core("rst_run", 0, 0, 0, 0);
        rst_n = 1'b1;

        // IDLE ignores branch, with and without start.
        drive(0, 0, 2'd2, 1, 15'd5);
        tick();
        expect_core("idle_br", 0, 0, 0, 0);
        drive(1, 0, 2'd0, 1, 15'd5);
        tick();
        expect_core("start_br", 0, 1, 3, 0);

        // Odd PC steering.
        drive(0, 0, 2'd1, 0, 15'd0);
        tick();
        expect_core("odd1", 1, 1, 3, 1);
        expect_steer("odd1", 0, 1, 0, 2);
        drive(0, 0, 2'd2, 0, 15'd0);
        tick();
        expect_core("odd3", 3, 1, 3, 3);
        expect_steer("odd3", 1, 1, 0, 2);
        drive(0, 0, 2'd1, 0, 15'd0);
        tick();
        expect_core("pc4", 4, 1, 3, 4);

        // Branch beats stall and issue; bubble consumes nothing.
        drive(0, 1, 2'd2, 1, 15'h9);
        tick();
        expect_core("br9", 9, 2, 0, 4);
        drive(0, 0, 2'd2, 0, 15'd0);
        tick();
        expect_core("bub9", 9, 1, 3, 4);
        expect_steer("bub9", 4, 1, 0, 2);

        // issue_cnt=3 and stall hold everything.
        drive(0, 0, 2'd3, 0, 15'd0);
        tick();
        expect_core("ic3a", 9, 1, 3, 4);
        tick();
        expect_core("ic3b", 9, 1, 3, 4);
        drive(0, 1, 2'd2, 0, 15'd0);
        tick();
        expect_core("stall", 9, 1, 3, 4);

        // End of program: PC=18 has one valid slot, clamp to 1, halt at 19.
        drive(0, 0, 2'd0, 1, 15'd18);
        tick();
        expect_core("br18", 18, 2, 0, 4);
        drive(0, 0, 2'd0, 0, 15'd0);
        tick();
        expect_core("pc18", 18, 1, 1, 4);
        drive(0, 0, 2'd2, 0, 15'd0);
        tick();
        expect_core("halt", 19, 3, 0, 5);
        tick();
        expect_core("halt_hold", 19, 3, 0, 5);

        // Leave HALT by branch.
        drive(0, 0, 2'd2, 1, 15'd0);
        tick();
        expect_core("hbr0", 0, 2, 0, 5);
        drive(0, 0, 2'd0, 0, 15'd0);
        tick();
        expect_core("hrun0", 0, 1, 3, 5);

        // Branch past the end: bubble, RUN with no valids, then HALT with acc=0.
        drive(0, 0, 2'd0, 1, 15'd25);
        tick();
        expect_core("br25", 25, 2, 0, 5);
        drive(0, 0, 2'd2, 0, 15'd0);
        tick();
        expect_core("run25", 25, 1, 0, 5);
        tick();
        expect_core("halt25", 25, 3, 0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
